input_port_vc_flit_decoder: RTL and testbench

INPUT_PORT_VC_FLIT_DECODER -- requirements
Module: input_port_vc_flit_decoder

---
 rtl/input_port_vc_flit_decoder.sv | 126 ++++++++++++
 tb/tb_input_port_vc_flit_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_vc_flit_decoder.sv
// Per-VC flit decoder: restores header context onto body/tail flits, flags protocol errors (QoS path: INPORT_DEC_QOS_EN).
// One registered output stage, 1 cycle latency; flit_rdy drops only while the held output is stalled by dec_rdy_i.
package input_port_vc_flit_decoder_pkg;
    // Look-ahead route: router output port selector (local plus mesh directions).
    typedef logic [2:0] io_port_t;
endpackage

module input_port_vc_flit_decoder
    import input_port_vc_flit_decoder_pkg::*;
#(
    parameter int VC_NUM = 4,
    parameter int ID_W = 6,
    parameter int QOS_W = 4,
    localparam int VC_IDX_W = $clog2(VC_NUM),
    localparam int LAR_W = $bits(io_port_t)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flit_v_i,
    output logic                flit_rdy_o,
    input  logic [VC_IDX_W-1:0] flit_vc_id_i,
    input  logic                flit_head_i,
    input  logic                flit_tail_i,
    input  logic [ID_W-1:0]     flit_tgt_id_i,
    input  logic [ID_W-1:0]     flit_src_id_i,
    input  logic [QOS_W-1:0]    flit_qos_i,
    input  logic [LAR_W-1:0]    flit_lar_i,
    output logic                dec_v_o,
    output logic [VC_IDX_W-1:0] dec_vc_id_o,
    output logic                dec_head_o,
    output logic                dec_tail_o,
    output logic [ID_W-1:0]     dec_tgt_id_o,
    output logic [ID_W-1:0]     dec_src_id_o,
    output logic [QOS_W-1:0]    dec_qos_o,
    output logic [LAR_W-1:0]    dec_lar_o,
    input  logic                dec_rdy_i,
    output logic [VC_NUM-1:0]   err_o
);

    typedef enum logic {IDLE, ACTIVE} vc_state_t;

    typedef struct packed {
        logic [ID_W-1:0]  tgt;
        logic [ID_W-1:0]  src;
        logic [LAR_W-1:0] lar;
    } ctx_t;

    vc_state_t vc_state [VC_NUM];
    ctx_t      vc_ctx   [VC_NUM];

    logic accept;
    logic cur_active;

    assign flit_rdy_o = !dec_v_o || dec_rdy_i;
    assign accept     = flit_v_i && flit_rdy_o;
    assign cur_active = (vc_state[flit_vc_id_i] == ACTIVE);

`ifdef INPORT_DEC_QOS_EN
    logic [QOS_W-1:0] vc_qos [VC_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_qos_o <= '0;
            for (int i = 0; i < VC_NUM; i++) vc_qos[i] <= '0;
        end else if (accept) begin
            if (flit_head_i) begin
                vc_qos[flit_vc_id_i] <= flit_qos_i;
                dec_qos_o            <= flit_qos_i;
            end else if (cur_active) begin
                dec_qos_o <= vc_qos[flit_vc_id_i];
            end
        end
    end
`else
    logic unused_qos;
    assign unused_qos = ^flit_qos_i;
    assign dec_qos_o  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_v_o      <= 1'b0;
            dec_vc_id_o  <= '0;
            dec_head_o   <= 1'b0;
            dec_tail_o   <= 1'b0;
            dec_tgt_id_o <= '0;
            dec_src_id_o <= '0;
            dec_lar_o    <= '0;
            err_o        <= '0;
            for (int i = 0; i < VC_NUM; i++) begin
                vc_state[i] <= IDLE;
                vc_ctx[i]   <= '0;
            end
        end else begin
            if (dec_rdy_i) dec_v_o <= 1'b0;
            if (accept) begin
                if (flit_head_i) begin
                    // A head on an open packet is an error but still starts a fresh packet.
                    if (cur_active) err_o[flit_vc_id_i] <= 1'b1;
                    vc_ctx[flit_vc_id_i]   <= '{tgt: flit_tgt_id_i, src: flit_src_id_i, lar: flit_lar_i};
                    vc_state[flit_vc_id_i] <= flit_tail_i ? IDLE : ACTIVE;
                    dec_v_o      <= 1'b1;
                    dec_vc_id_o  <= flit_vc_id_i;
                    dec_head_o   <= 1'b1;
                    dec_tail_o   <= flit_tail_i;
                    dec_tgt_id_o <= flit_tgt_id_i;
                    dec_src_id_o <= flit_src_id_i;
                    dec_lar_o    <= flit_lar_i;
                end else if (cur_active) begin
                    if (flit_tail_i) vc_state[flit_vc_id_i] <= IDLE;
                    dec_v_o      <= 1'b1;
                    dec_vc_id_o  <= flit_vc_id_i;
                    dec_head_o   <= 1'b0;
                    dec_tail_o   <= flit_tail_i;
                    dec_tgt_id_o <= vc_ctx[flit_vc_id_i].tgt;
                    dec_src_id_o <= vc_ctx[flit_vc_id_i].src;
                    dec_lar_o    <= vc_ctx[flit_vc_id_i].lar;
                end else begin
                    // Orphan body/tail: consumed and dropped.
                    err_o[flit_vc_id_i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_port_vc_flit_decoder.sv
// Randomized + directed bench for input_port_vc_flit_decoder against a packet-level queue model.
module tb_input_port_vc_flit_decoder;

    localparam int VC_NUM = 4;
    localparam int ID_W = 6;
    localparam int QOS_W = 4;
    localparam int VC_IDX_W = 2;
    localparam int LAR_W = 3;
`ifdef INPORT_DEC_QOS_EN
    localparam bit QOS_ON = 1'b1;
`else
    localparam bit QOS_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                flit_v_i;
    logic                flit_rdy_o;
    logic [VC_IDX_W-1:0] flit_vc_id_i;
    logic                flit_head_i;
    logic                flit_tail_i;
    logic [ID_W-1:0]     flit_tgt_id_i;
    logic [ID_W-1:0]     flit_src_id_i;
    logic [QOS_W-1:0]    flit_qos_i;
    logic [LAR_W-1:0]    flit_lar_i;
    logic                dec_v_o;
    logic [VC_IDX_W-1:0] dec_vc_id_o;
    logic                dec_head_o;
    logic                dec_tail_o;
    logic [ID_W-1:0]     dec_tgt_id_o;
    logic [ID_W-1:0]     dec_src_id_o;
    logic [QOS_W-1:0]    dec_qos_o;
    logic [LAR_W-1:0]    dec_lar_o;
    logic                dec_rdy_i;
    logic [VC_NUM-1:0]   err_o;

    input_port_vc_flit_decoder #(.VC_NUM(VC_NUM), .ID_W(ID_W), .QOS_W(QOS_W)) dut (
        .clk(clk), .rst(rst),
        .flit_v_i(flit_v_i), .flit_rdy_o(flit_rdy_o),
        .flit_vc_id_i(flit_vc_id_i), .flit_head_i(flit_head_i), .flit_tail_i(flit_tail_i),
        .flit_tgt_id_i(flit_tgt_id_i), .flit_src_id_i(flit_src_id_i),
        .flit_qos_i(flit_qos_i), .flit_lar_i(flit_lar_i),
        .dec_v_o(dec_v_o), .dec_vc_id_o(dec_vc_id_o), .dec_head_o(dec_head_o),
        .dec_tail_o(dec_tail_o), .dec_tgt_id_o(dec_tgt_id_o), .dec_src_id_o(dec_src_id_o),
        .dec_qos_o(dec_qos_o), .dec_lar_o(dec_lar_o),
        .dec_rdy_i(dec_rdy_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Packet-level model: open/closed flag and saved header per VC, one-deep queue of outputs.
    typedef struct {
        int vc;
        bit head;
        bit tail;
        int tgt;
        int src;
        int qos;
        int lar;
    } exp_t;

    exp_t q[$];
    bit   m_open [VC_NUM];
    int   m_tgt  [VC_NUM];
    int   m_src  [VC_NUM];
    int   m_qos  [VC_NUM];
    int   m_lar  [VC_NUM];
    int   m_err;

    int n_checks = 0;
    int n_fail = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_err = 0;
        for (int i = 0; i < VC_NUM; i++) begin
            m_open[i] = 0;
            m_tgt[i] = 0; m_src[i] = 0; m_qos[i] = 0; m_lar[i] = 0;
        end
    endfunction

    function automatic void compare_all();
        chk("dec_v", dec_v_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("dec_vc", dec_vc_id_o, q[0].vc);
            chk("dec_head", dec_head_o, q[0].head);
            chk("dec_tail", dec_tail_o, q[0].tail);
            chk("dec_tgt", dec_tgt_id_o, q[0].tgt);
            chk("dec_src", dec_src_id_o, q[0].src);
            chk("dec_qos", dec_qos_o, QOS_ON ? q[0].qos : 0);
            chk("dec_lar", dec_lar_o, q[0].lar);
        end
        chk("err", err_o, m_err);
    endfunction

    function automatic void model_update();
        exp_t e;
        int   vc;
        bit   rdy;
        vc  = int'(flit_vc_id_i);
        rdy = (q.size() == 0) || dec_rdy_i;
        if (q.size() != 0 && dec_rdy_i) void'(q.pop_front());
        if (flit_v_i && rdy) begin
            if (flit_head_i) begin
                if (m_open[vc]) m_err |= (1 << vc);
                m_tgt[vc] = flit_tgt_id_i;
                m_src[vc] = flit_src_id_i;
                m_qos[vc] = flit_qos_i;
                m_lar[vc] = flit_lar_i;
                m_open[vc] = !flit_tail_i;
                e = '{vc, 1'b1, flit_tail_i, m_tgt[vc], m_src[vc], m_qos[vc], m_lar[vc]};
                q.push_back(e);
            end else if (m_open[vc]) begin
                e = '{vc, 1'b0, flit_tail_i, m_tgt[vc], m_src[vc], m_qos[vc], m_lar[vc]};
                q.push_back(e);
                if (flit_tail_i) m_open[vc] = 0;
            end else begin
                m_err |= (1 << vc);
            end
        end
    endfunction

    // One cycle: check outputs, drive the next inputs, check readiness, advance model.
    task automatic step(input bit v, input int vc, input bit hd, input bit tl,
                        input int tgt, input int src, input int qos, input int lar, input bit rdy);
        @(negedge clk);
        compare_all();
        flit_v_i      = v;
        flit_vc_id_i  = VC_IDX_W'(vc);
        flit_head_i   = hd;
        flit_tail_i   = tl;
        flit_tgt_id_i = ID_W'(tgt);
        flit_src_id_i = ID_W'(src);
        flit_qos_i    = QOS_W'(qos);
        flit_lar_i    = LAR_W'(lar);
        dec_rdy_i     = rdy;
        #1;
        chk("flit_rdy", flit_rdy_o, (q.size() == 0) || rdy);
        model_update();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        flit_v_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_dec_v", dec_v_o, 0);
        chk("rst_dec_tgt", dec_tgt_id_o, 0);
        chk("rst_dec_src", dec_src_id_o, 0);
        chk("rst_dec_qos", dec_qos_o, 0);
        chk("rst_err", err_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flit_v_i = 0; flit_vc_id_i = 0; flit_head_i = 0; flit_tail_i = 0;
        flit_tgt_id_i = 0; flit_src_id_i = 0; flit_qos_i = 0; flit_lar_i = 0;
        dec_rdy_i = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_dec_v", dec_v_o, 0);
        chk("reset_dec_lar", dec_lar_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_rdy", flit_rdy_o, 1);
        rst = 1'b0;

        // Single packet on VC1, body header inputs must be ignored.
        step(1, 1, 1, 0, 5, 2, 9, 3, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("p_head_tgt", dec_tgt_id_o, 5);
        chk("p_head_vc", dec_vc_id_o, 1);
        chk("p_head_qos", dec_qos_o, QOS_ON ? 9 : 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("p_body1_tgt", dec_tgt_id_o, 5);
        chk("p_body1_src", dec_src_id_o, 2);
        step(1, 1, 0, 1, 0, 0, 0, 0, 1);
        chk("p_body2_qos", dec_qos_o, QOS_ON ? 9 : 0);
        idle();
        chk("p_tail_flag", dec_tail_o, 1);
        chk("p_tail_tgt", dec_tgt_id_o, 5);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("p_vc1_idle_err", err_o, 4'b0010);
        chk("p_vc1_drop", dec_v_o, 0);

        // Interleaved packets on VC0 and VC2.
        do_reset();
        step(1, 0, 1, 0, 3, 1, 2, 1, 1);
        step(1, 2, 1, 0, 7, 4, 5, 2, 1);
        step(1, 0, 0, 0, 60, 60, 0, 0, 1);
        step(1, 2, 0, 0, 60, 60, 0, 0, 1);
        chk("il_body0_tgt", dec_tgt_id_o, 3);
        step(1, 0, 0, 1, 60, 60, 0, 0, 1);
        chk("il_body2_tgt", dec_tgt_id_o, 7);
        step(1, 2, 0, 1, 60, 60, 0, 0, 1);
        idle();
        chk("il_tail2_tgt", dec_tgt_id_o, 7);
        chk("il_err", err_o, 0);

        // Backpressure for three cycles.
        step(1, 0, 1, 0, 12, 13, 1, 4, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_rdy_low", flit_rdy_o, 0);
        chk("bp_hold_tgt", dec_tgt_id_o, 12);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_hold_head", dec_head_o, 1);
        step(1, 0, 0, 1, 0, 0, 0, 0, 1);
        idle();
        chk("bp_resume_body", dec_head_o, 0);
        chk("bp_resume_tail", dec_tail_o, 1);
        idle();

        // Error cases: orphan body on VC3, head on open VC0.
        do_reset();
        step(1, 3, 0, 0, 1, 1, 1, 1, 1);
        idle();
        chk("e_vc3_err", err_o, 4'b1000);
        chk("e_vc3_drop", dec_v_o, 0);
        step(1, 0, 1, 0, 4, 4, 4, 4, 1);
        step(1, 0, 1, 0, 11, 6, 3, 5, 1);
        idle();
        chk("e_rehead_err", err_o, 4'b1001);
        chk("e_rehead_tgt", dec_tgt_id_o, 11);

        // Reset in the middle of a VC1 packet.
        do_reset();
        step(1, 1, 1, 0, 9, 8, 7, 6, 1);
        idle();
        chk("mr_pre_v", dec_v_o, 1);
        do_reset();
        step(1, 1, 0, 1, 0, 0, 0, 0, 1);
        idle();
        chk("mr_tail_err", err_o, 4'b0010);
        chk("mr_tail_drop", dec_v_o, 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 70, $urandom_range(VC_NUM - 1),
                 $urandom_range(99) < 30, $urandom_range(99) < 30,
                 $urandom_range(63), $urandom_range(63), $urandom_range(15),
                 $urandom_range(7), $urandom_range(99) < 75);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
